// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : cpu_pkg
//  Purpose  : Opcodes, forwarding-select encodings and flag-update mask
//             shared by the 16-bit 5-stage CPU pipeline stages.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'b0000;
    localparam opcode_t OP_SUB = 4'b0001;
    localparam opcode_t OP_XOR = 4'b0010;
    localparam opcode_t OP_SLL = 4'b0100;
    localparam opcode_t OP_SRA = 4'b0101;
    localparam opcode_t OP_ROR = 4'b0110;
    localparam opcode_t OP_LW  = 4'b1000;
    localparam opcode_t OP_SW  = 4'b1001;

    // EX operand-mux select encoding
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Returns {Z, V, N} write enables for an opcode
    function automatic logic [2:0] flag_update_mask(input opcode_t op);
        logic [2:0] mask;
        mask = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
            default:                        mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_select
//  Purpose  : Forwarding comparator and MEM-over-WB priority for one EX operand.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_select
    import cpu_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic          mem_regWrite,
    input  logic [RW-1:0] mem_regW,
    input  logic          wb_regWrite,
    input  logic [RW-1:0] wb_regW,
    input  logic [RW-1:0] src_reg,
    output logic [1:0]    sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // R0 is hardwired zero, so a write to it is never a real producer
    assign w_mem_hit = mem_regWrite && (mem_regW != '0) && (mem_regW == src_reg);
    assign w_wb_hit  = wb_regWrite  && (wb_regW  != '0) && (wb_regW  == src_reg);

    always_comb begin
        sel = FWD_NONE;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_select
`default_nettype wire

// File: rtl/ex_mem_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_fwd_stage
//  Purpose  : EX/MEM pipeline register, architectural Z/V/N flags, EX operand
//             forwarding selects and load-use stall request.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_fwd_stage
    import cpu_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_aluOut,
    input  logic [DW-1:0] ex_storeData,
    input  logic [RW-1:0] ex_regW,
    input  logic          ex_regWrite,
    input  logic          ex_memRead,
    input  logic          ex_memWrite,
    input  logic [3:0]    ex_opcode,
    input  logic          ex_zero,
    input  logic          ex_overflow,
    input  logic          ex_neg,
    input  logic [RW-1:0] ex_rs,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          wb_regWrite,
    input  logic [RW-1:0] wb_regW,
    output logic          mem_valid,
    output logic          mem_regWrite,
    output logic          mem_memRead,
    output logic          mem_memWrite,
    output logic [RW-1:0] mem_regW,
    output logic [DW-1:0] MEM_faddress,
    output logic [DW-1:0] mem_storeData,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic [1:0]    ForwardA,
    output logic [1:0]    ForwardB,
    output logic          load_use_stall
);

    logic          r_valid;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [RW-1:0] r_reg_w;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_store_data;
    logic          r_flag_z;
    logic          r_flag_v;
    logic          r_flag_n;

    logic          w_live;
    logic [2:0]    w_flag_mask;

    // An invalid EX slot is handled exactly like a flushed one
    assign w_live      = ex_valid && !flush;
    assign w_flag_mask = flag_update_mask(ex_opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_w      <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_flag_z     <= 1'b0;
            r_flag_v     <= 1'b0;
            r_flag_n     <= 1'b0;
        end else if (!stall) begin
            r_valid      <= w_live;
            r_reg_write  <= w_live && ex_regWrite;
            r_mem_read   <= w_live && ex_memRead;
            r_mem_write  <= w_live && ex_memWrite;
            r_reg_w      <= ex_regW;
            r_addr       <= ex_aluOut;
            r_store_data <= ex_storeData;
            if (w_live) begin
                if (w_flag_mask[2]) r_flag_z <= ex_zero;
                if (w_flag_mask[1]) r_flag_v <= ex_overflow;
                if (w_flag_mask[0]) r_flag_n <= ex_neg;
            end
        end
    end

    assign mem_valid     = r_valid;
    assign mem_regWrite  = r_reg_write;
    assign mem_memRead   = r_mem_read;
    assign mem_memWrite  = r_mem_write;
    assign mem_regW      = r_reg_w;
    assign MEM_faddress  = r_addr;
    assign mem_storeData = r_store_data;
    assign flag_z        = r_flag_z;
    assign flag_v        = r_flag_v;
    assign flag_n        = r_flag_n;

    fwd_select #(
        .RW (RW)
    ) u_fwd_a (
        .mem_regWrite (r_reg_write),
        .mem_regW     (r_reg_w),
        .wb_regWrite  (wb_regWrite),
        .wb_regW      (wb_regW),
        .src_reg      (ex_rs),
        .sel          (ForwardA)
    );

    fwd_select #(
        .RW (RW)
    ) u_fwd_b (
        .mem_regWrite (r_reg_write),
        .mem_regW     (r_reg_w),
        .wb_regWrite  (wb_regWrite),
        .wb_regW      (wb_regW),
        .src_reg      (ex_rt),
        .sel          (ForwardB)
    );

    // MEM_faddress carries the load address, so a dependent ID instruction must wait
    assign load_use_stall = ex_valid && ex_memRead && ex_regWrite && (ex_regW != '0) &&
                            ((ex_regW == id_rs) || (ex_regW == id_rt));

endmodule : ex_mem_fwd_stage
`default_nettype wire
